// File: rtl/poisson_spike_gen.sv
// Multi-channel Bernoulli spike source: one Galois LFSR per channel, thresholded
// against a per-channel probability, with saturating spike and cycle counters.
module poisson_spike_gen #(
  parameter int          N_CH         = 4,
  parameter int          LFSR_W       = 16,
  parameter int          PROB_W       = 8,
  parameter int          CNT_W        = 16,
  parameter logic [15:0] SEED_DEFAULT = 16'h0001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed,
  input  logic [N_CH*PROB_W-1:0]   prob,
  input  logic                     cnt_clear,
  output logic [N_CH-1:0]          spike,
  output logic                     spike_valid,
  output logic [N_CH*CNT_W-1:0]    spike_cnt,
  output logic [CNT_W-1:0]         cycle_cnt
);

  if (!(LFSR_W == 16 || LFSR_W == 32) || PROB_W > LFSR_W) begin : g_bad_params
    $error("poisson_spike_gen: LFSR_W must be 16 or 32 and PROB_W <= LFSR_W");
  end

  localparam logic [LFSR_W-1:0] TAPS = (LFSR_W == 32) ? LFSR_W'(32'h8020_0003)
                                                       : LFSR_W'(16'hB400);

  logic [N_CH-1:0][LFSR_W-1:0] lfsr;
  logic [N_CH-1:0][CNT_W-1:0]  cnt;
  logic [N_CH-1:0]             hit;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : '0);
  endfunction

  // Channels get distinct rotations of one nonzero base so they never start in lockstep.
  function automatic logic [LFSR_W-1:0] seed_for(input logic [LFSR_W-1:0] base, input int c);
    logic [LFSR_W-1:0] s;
    int k;
    s = (base == '0) ? LFSR_W'(1) : base;
    k = (3 * c) % LFSR_W;
    return (s << k) | (s >> (LFSR_W - k));
  endfunction

  // NOTE: combinational outputs get a default before the loop so no latch is inferred.
  always_comb begin
    hit = '0;
    for (int c = 0; c < N_CH; c++) begin
      hit[c] = lfsr[c][PROB_W-1:0] < prob[c*PROB_W +: PROB_W];
    end
  end

  // NOTE: all state updates are non-blocking so every channel sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        lfsr[c] <= seed_for(LFSR_W'(SEED_DEFAULT), c);
      end
      spike       <= '0;
      spike_valid <= 1'b0;
    end else if (seed_load) begin
      for (int c = 0; c < N_CH; c++) begin
        lfsr[c] <= seed_for(seed, c);
      end
      spike       <= '0;
      spike_valid <= 1'b0;
    end else if (en) begin
      for (int c = 0; c < N_CH; c++) begin
        lfsr[c] <= lfsr_step(lfsr[c]);
      end
      spike       <= hit;
      spike_valid <= 1'b1;
    end else begin
      spike       <= '0;
      spike_valid <= 1'b0;
    end
  end

  // Counters track the spike register edge-for-edge; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      cycle_cnt <= '0;
    end else if (cnt_clear) begin
      cnt       <= '0;
      cycle_cnt <= '0;
    end else if (en && !seed_load) begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        if (hit[c] && cnt[c] != '1) cnt[c] <= cnt[c] + 1'b1;
      end
    end
  end

  assign spike_cnt = cnt;

endmodule

// File: tb/tb_poisson_spike_gen.sv
// Self-checking bench for poisson_spike_gen: directed phases plus randomized
// traffic compared cycle by cycle against an arithmetic reference model.
module tb_poisson_spike_gen;

  localparam int N_CH = 4;

  logic        clk = 1'b0;
  logic        rst, en, seed_load, cnt_clear;
  logic [15:0] seed;
  logic [31:0] prob;
  logic [3:0]  spike;
  logic        spike_valid;
  logic [63:0] spike_cnt;
  logic [15:0] cycle_cnt;

  int errors = 0;
  int checks = 0;
  int zero_seen = 0;

  poisson_spike_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .seed_load   (seed_load),
    .seed        (seed),
    .prob        (prob),
    .cnt_clear   (cnt_clear),
    .spike       (spike),
    .spike_valid (spike_valid),
    .spike_cnt   (spike_cnt),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        if (dut.lfsr[c] == 16'h0) zero_seen++;
      end
    end
  end

  // Reference model state
  logic [15:0] m_lfsr [N_CH];
  logic [3:0]  m_spike;
  logic        m_valid;
  int unsigned m_cnt [N_CH];
  int unsigned m_cyc;

  function automatic logic [15:0] m_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] m_seed(input logic [15:0] base, input int c);
    logic [15:0] s;
    int k;
    s = (base == 16'h0) ? 16'h0001 : base;
    k = (3 * c) % 16;
    if (k == 0) return s;
    return (s << k) | (s >> (16 - k));
  endfunction

  task automatic m_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_lfsr[c] = m_seed(16'h0001, c);
      m_cnt[c]  = 0;
    end
    m_spike = '0;
    m_valid = 1'b0;
    m_cyc   = 0;
  endtask

  task automatic m_edge();
    if (seed_load) begin
      for (int c = 0; c < N_CH; c++) m_lfsr[c] = m_seed(seed, c);
      m_spike = '0;
      m_valid = 1'b0;
    end else if (en) begin
      for (int c = 0; c < N_CH; c++) begin
        m_spike[c] = (m_lfsr[c] % 256) < prob[c*8 +: 8];
        m_lfsr[c]  = m_next(m_lfsr[c]);
      end
      m_valid = 1'b1;
    end else begin
      m_spike = '0;
      m_valid = 1'b0;
    end
    if (cnt_clear) begin
      m_cyc = 0;
      for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
    end else if (en && !seed_load) begin
      if (m_cyc < 65535) m_cyc++;
      for (int c = 0; c < N_CH; c++) begin
        if (m_spike[c] && m_cnt[c] < 65535) m_cnt[c]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_spike"}, 64'(spike), 64'(m_spike));
    check({tag, "_valid"}, 64'(spike_valid), 64'(m_valid));
    check({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'(m_cyc));
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("%s_cnt%0d", tag, c), 64'(spike_cnt[c*16 +: 16]), 64'(m_cnt[c]));
      check($sformatf("%s_lfsr%0d", tag, c), 64'(dut.lfsr[c]), 64'(m_lfsr[c]));
    end
  endtask

  initial begin
    logic [15:0] seq [3];
    seq = '{16'hB400, 16'h5A00, 16'h2D00};

    rst = 1'b1; en = 1'b0; seed_load = 1'b0; cnt_clear = 1'b0; seed = '0; prob = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Seed load with seed=1, then en held
    seed_load = 1'b1; seed = 16'h0001;
    tick();
    seed_load = 1'b0;
    check_all("seedload");
    check("seed_ch0", 64'(dut.lfsr[0]), 64'h0001);
    check("seed_ch1", 64'(dut.lfsr[1]), 64'h0008);
    check("valid_before_en", 64'(spike_valid), 64'h0);
    en = 1'b1; prob = 32'h8040_20FF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("seq_ch0_%0d", i), 64'(dut.lfsr[0]), 64'(seq[i]));
      check_all($sformatf("seq%0d", i));
    end

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      en        = ($urandom_range(0, 9) < 7);
      prob      = $urandom;
      cnt_clear = ($urandom_range(0, 49) == 0);
      seed_load = ($urandom_range(0, 99) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick();
      check_all("rand");
    end

    // seed_load beats en; seed=0 behaves as seed=1
    seed_load = 1'b1; en = 1'b1; seed = 16'h0000; cnt_clear = 1'b0;
    tick();
    seed_load = 1'b0;
    check("prio_spike", 64'(spike), 64'h0);
    check("prio_valid", 64'(spike_valid), 64'h0);
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("prio_lfsr%0d", c), 64'(dut.lfsr[c]), 64'(m_seed(16'h0001, c)));
    end

    // Full-period rate check
    en = 1'b0; cnt_clear = 1'b1; prob = 32'hFF80_0100;
    tick();
    cnt_clear = 1'b0; en = 1'b1;
    repeat (65535) tick();
    check("rate_cycle", 64'(cycle_cnt), 64'd65535);
    check("rate_ch0", 64'(spike_cnt[15:0]), 64'd0);
    check("rate_ch1", 64'(spike_cnt[31:16]), 64'd255);
    check("rate_ch2", 64'(spike_cnt[47:32]), 64'd32767);
    check("rate_ch3", 64'(spike_cnt[63:48]), 64'd65279);
    check_all("rate");

    // Saturation
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("sat_cycle%0d", i), 64'(cycle_cnt), 64'd65535);
    end
    check_all("sat");

    // cnt_clear wins over increment, then counting resumes
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("clr_cycle", 64'(cycle_cnt), 64'd0);
    check("clr_spike_cnt", spike_cnt, 64'd0);
    check_all("clr");
    tick();
    check("resume_cycle", 64'(cycle_cnt), 64'd1);
    check_all("resume");

    // en=0 holds LFSRs
    en = 1'b0;
    repeat (5) begin
      tick();
      check("gate_spike", 64'(spike), 64'h0);
      check_all("gate");
    end

    // Asynchronous reset mid-run
    en = 1'b1; prob = 32'hFFFF_FFFF;
    repeat (3) tick();
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    check("arst_valid", 64'(spike_valid), 64'h0);
    check("arst_lfsr0", 64'(dut.lfsr[0]), 64'h0001);
    check_all("arst");
    #1;
    rst = 1'b0;
    tick();
    check_all("post_arst");

    check("lfsr_never_zero", 64'(zero_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
